// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared types and constants for the sequential divider.
//   state_t   - controller states IDLE / RUN / DONE
//   DEFAULT_N - default operand/result width
package seq_divider_pkg;

  localparam int DEFAULT_N = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_addsub.sv
// div_addsub: W-bit adder/subtractor with carry-out.
//   a, b   : operands
//   sub    : 1 = a - b (two's complement add of ~b + 1), 0 = a + b
//   result : W-bit sum/difference
//   cout   : carry-out; in subtract mode 1 means no borrow (a >= b)
module div_addsub #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] result,
  output logic         cout
);

  logic [W-1:0] b_eff;

  assign b_eff         = sub ? ~b : b;
  assign {cout, result} = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};

endmodule

// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one quotient bit per clock.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : begin a division (sampled only in IDLE)
//   dividend, divisor   : N-bit operands, captured on the accepting edge
//   busy                : high in RUN and DONE
//   done                : one-cycle pulse, results valid
//   quotient, remainder : results, held until the next accepted start
//   div_by_zero         : captured divisor was zero
// Build option: define SEQ_DIVIDER_SIGNED_EN for two's complement operands
// (magnitudes are divided, signs fixed up on the RUN->DONE edge).
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic [N-1:0]  acc_q;     // dividend bits shifting out, quotient bits shifting in
  logic [N-1:0]  acc_r;     // partial remainder
  logic [N-1:0]  dvs;       // captured divisor (magnitude in signed builds)
  logic [N:0]    shifted;
  logic [N:0]    diff;
  logic          no_borrow;
  logic [N-1:0]  r_step;
  logic [N-1:0]  q_step;
  logic          last;
  logic          unused;

  // Trial subtract on N+1 bits: the shifted remainder can reach 2*divisor-1,
  // which needs one bit more than the operands.
  assign shifted = {acc_r, acc_q[N-1]};

  div_addsub #(.W(N + 1)) u_sub (
    .a      (shifted),
    .b      ({1'b0, dvs}),
    .sub    (1'b1),
    .result (diff),
    .cout   (no_borrow)
  );

  // After a successful subtract the difference is below the divisor, so its
  // top bit is always zero.
  assign unused = diff[N];

  assign r_step = no_borrow ? diff[N-1:0] : shifted[N-1:0];
  assign q_step = {acc_q[N-2:0], no_borrow};
  assign last   = (cnt == LAST);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q, neg_r;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      acc_q       <= '0;
      acc_r       <= '0;
      dvs         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt         <= '0;
          acc_r       <= '0;
          div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
          acc_q <= dividend[N-1] ? -dividend : dividend;
          dvs   <= divisor[N-1]  ? -divisor  : divisor;
          neg_q <= dividend[N-1] ^ divisor[N-1];
          neg_r <= dividend[N-1];
`else
          acc_q <= dividend;
          dvs   <= divisor;
`endif
        end
        RUN: begin
          acc_r <= r_step;
          acc_q <= q_step;
          cnt   <= last ? '0 : cnt + CW'(1);
          if (last) begin
            div_by_zero <= (dvs == '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
            // A zero divisor yields all-ones regardless of operand signs;
            // the remainder sign fix-up restores the original dividend.
            if (dvs == '0)  quotient <= '1;
            else            quotient <= neg_q ? -q_step : q_step;
            remainder <= neg_r ? -r_step : r_step;
`else
            // With a zero divisor every step succeeds: quotient is all ones
            // and the dividend bits end up unchanged in the remainder.
            quotient  <= q_step;
            remainder <= r_step;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
  } res_t;

  typedef struct packed {
    logic [N-1:0] dd;
    logic [N-1:0] dv;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
  } vec_t;

  res_t         sb[$];
  res_t         last_res;
  vec_t         tbl[8];
  int           checks = 0;
  int           errors = 0;

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference division using the language operators.
  function automatic res_t model(input logic [N-1:0] dd, input logic [N-1:0] dv);
    res_t m;
    int a, b;
    logic [31:0] qi, ri;
    if (dv == '0) begin
      m.q = '1; m.r = dd; m.z = 1'b1;
      return m;
    end
`ifdef SEQ_DIVIDER_SIGNED_EN
    a = dd[N-1] ? int'(dd) - (1 << N) : int'(dd);
    b = dv[N-1] ? int'(dv) - (1 << N) : int'(dv);
`else
    a = int'(dd);
    b = int'(dv);
`endif
    qi = a / b;
    ri = a % b;
    m.q = qi[N-1:0];
    m.r = ri[N-1:0];
    m.z = 1'b0;
    return m;
  endfunction

  // Advance one clock, sample at the falling edge, retire any done pulse.
  task automatic tick();
    res_t e;
    @(posedge clk);
    @(negedge clk);
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", {31'd0, done}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("quotient", {28'd0, quotient}, {28'd0, e.q});
        chk("remainder", {28'd0, remainder}, {28'd0, e.r});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
        last_res = e;
      end
    end
  endtask

  task automatic run_div(input logic [N-1:0] dd, input logic [N-1:0] dv, input res_t exp);
    start = 1'b1; dividend = dd; divisor = dv;
    sb.push_back(exp);
    tick();
    start = 1'b0;
    dividend = N'($urandom); divisor = N'($urandom);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    chk("hold_quotient", {28'd0, quotient}, {28'd0, last_res.q});
    chk("hold_remainder", {28'd0, remainder}, {28'd0, last_res.r});
    for (int k = 1; k <= N; k++) begin
      tick();
      chk("done_latency", {31'd0, done}, {31'd0, (k == N)});
    end
    tick();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_not_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
`ifdef SEQ_DIVIDER_SIGNED_EN
    tbl = '{'{4'h9, 4'h2, 4'hD, 4'hF, 1'b0},
            '{4'h8, 4'hF, 4'h8, 4'h0, 1'b0},
            '{4'h7, 4'hE, 4'hD, 4'h1, 1'b0},
            '{4'h5, 4'h0, 4'hF, 4'h5, 1'b1},
            '{4'hD, 4'h0, 4'hF, 4'hD, 1'b1},
            '{4'h8, 4'h1, 4'h8, 4'h0, 1'b0},
            '{4'h6, 4'h3, 4'h2, 4'h0, 1'b0},
            '{4'hE, 4'h3, 4'h0, 4'hE, 1'b0}};
`else
    tbl = '{'{4'd13, 4'd3,  4'd4,  4'd1, 1'b0},
            '{4'd7,  4'd0,  4'd15, 4'd7, 1'b1},
            '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0},
            '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0},
            '{4'd8,  4'd9,  4'd0,  4'd8, 1'b0},
            '{4'd14, 4'd4,  4'd3,  4'd2, 1'b0},
            '{4'd15, 4'd2,  4'd7,  4'd1, 1'b0},
            '{4'd0,  4'd0,  4'd15, 4'd0, 1'b1}};
`endif
    last_res = '0;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quotient", {28'd0, quotient}, 32'd0);
    chk("rst_remainder", {28'd0, remainder}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;

    // Table vectors
    for (int i = 0; i < 8; i++)
      run_div(tbl[i].dd, tbl[i].dv, '{q: tbl[i].q, r: tbl[i].r, z: tbl[i].z});

    // Back-to-back with start held: second operation accepted on first IDLE cycle
    start = 1'b1; dividend = 4'd15; divisor = 4'd1;
    sb.push_back(model(4'd15, 4'd1));
    tick();
    dividend = 4'd9; divisor = 4'd6;
    sb.push_back(model(4'd9, 4'd6));
    for (int k = 1; k <= N; k++) begin
      tick();
      chk("b2b_first_latency", {31'd0, done}, {31'd0, (k == N)});
    end
    tick();
    chk("b2b_idle_gap", {31'd0, busy}, 32'd0);
    tick();
    chk("b2b_second_accept", {31'd0, busy}, 32'd1);
    start = 1'b0;
    for (int k = 1; k <= N; k++) begin
      tick();
      chk("b2b_second_latency", {31'd0, done}, {31'd0, (k == N)});
    end
    tick();

    // start pulsed during RUN must be ignored
    start = 1'b1; dividend = 4'd11; divisor = 4'd5;
    sb.push_back(model(4'd11, 4'd5));
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; dividend = 4'd2; divisor = 4'd1;
    tick();
    start = 1'b0;
    for (int k = 3; k <= N; k++) begin
      tick();
      chk("ignore_latency", {31'd0, done}, {31'd0, (k == N)});
    end
    for (int k = 0; k < 4; k++) tick();
    chk("ignore_idle", {31'd0, busy}, 32'd0);

    // Reset mid-RUN clears everything immediately
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    tick();
    start = 1'b0;
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_quotient", {28'd0, quotient}, 32'd0);
    chk("midrst_remainder", {28'd0, remainder}, 32'd0);
    chk("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
    last_res = '0;
    tick();
    rst_n = 1'b1;
    run_div(4'd5, 4'd5, model(4'd5, 4'd5));

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: N, default 4, sets the operand and result width in bits; legal range is N >= 2.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 dividend  input  N  numerator; captured on the accepting edge.
REQ-006 divisor  input  N  denominator; captured on the accepting edge.
REQ-007 busy  output  1  high while in RUN or DONE.
REQ-008 done  output  1  one-cycle pulse marking that the results are valid.
REQ-009 quotient  output  N  result quotient; held until the next accepted start.
REQ-010 remainder  output  N  result remainder; held until the next accepted start.
REQ-011 div_by_zero  output  1  set with done when the captured divisor is 0; held with the results.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
REQ-013 IDLE->RUN SHALL occur on an edge where start=1, capturing dividend and divisor and clearing div_by_zero.
REQ-014 RUN SHALL perform one restoring-division step per cycle, for exactly N cycles counted by a log2(N)+1-bit counter.
REQ-015 Each step SHALL shift {partial remainder, quotient} left by 1, trial-subtract the divisor with an (N+1)-bit subtract and carry-out, and on no-borrow keep the difference and set quotient bit 0 to 1, else restore.
REQ-016 RUN->DONE SHALL occur after the Nth step, and DONE->IDLE after exactly one cycle.
REQ-017 done SHALL be high only in DONE, which is the (N+1)th cycle after the accepting edge; for N=4, done is high after edge 5.
REQ-018 quotient and remainder SHALL update only on the RUN->DONE edge, so the previous results stay visible while busy.
REQ-019 Divisor = 0 SHALL keep the same latency and produce quotient = all ones, remainder = dividend and div_by_zero = 1.
REQ-020 start asserted in RUN or DONE SHALL be ignored with no queuing; a start held high through DONE is accepted on the first IDLE cycle.
REQ-021 Unsigned arithmetic is the default; no result SHALL overflow the N-bit outputs.

Reset
REQ-022 rst_n=0 SHALL immediately force IDLE and set busy=0, done=0, quotient=0, remainder=0, div_by_zero=0 and the counter to 0, including mid-RUN.
REQ-023 After rst_n deasserts, the first edge with start=1 SHALL be accepted normally.

Configuration
REQ-024 With macro SEQ_DIVIDER_SIGNED_EN defined, operands SHALL be treated as two's complement:
- the unit divides magnitudes;
- the quotient is negated when the operand signs differ, truncating toward zero;
- the remainder takes the dividend's sign;
- -2^(N-1) / -1 gives quotient = -2^(N-1) and remainder = 0;
- divide-by-zero gives quotient = all ones and remainder = dividend;
- latency is unchanged, with sign fix-up done on the RUN->DONE edge.
REQ-025 Without SEQ_DIVIDER_SIGNED_EN, the behaviour SHALL be purely unsigned and no sign logic SHALL be synthesized.

Structure
REQ-026 Package seq_divider_pkg SHALL hold the state typedef (IDLE/RUN/DONE) and the default width constant.
REQ-027 The trial subtraction SHALL be a sub-module div_addsub: parameterised width, add/sub select, carry-out.

Verification
REQ-028 N=4, 13/3 -> after edge 5: done=1, quotient=4, remainder=1, div_by_zero=0; done=0 on the following cycle.
REQ-029 N=4, 7/0 -> quotient=15, remainder=7, div_by_zero=1, with done after edge 5.
REQ-030 N=4, 15/1 then back-to-back 9/6 (start held) -> results 15 r0, then 1 r3; the second start is accepted on the first IDLE cycle after DONE.
REQ-031 start pulsed with 2/1 during RUN of 11/5 -> ignored; result 2 r1 with a single done pulse.
REQ-032 rst_n pulsed low mid-RUN -> all outputs 0 immediately; the next 5/5 gives 1 r0 with normal latency.
REQ-033 SEQ_DIVIDER_SIGNED_EN, N=4, -7/2 -> quotient=4'hD (-3) and remainder=4'hF (-1); -8/-1 -> quotient=4'h8, remainder=0.
